// File: rtl/tm1638_byte_engine.sv
// Bit-serial byte engine for a TM1638 board: shifts one byte LSB-first out on DIO or in from DIO under SCLK.
// Optional macro TM_BYTE_DONE_EN adds a one-clk done pulse when a complete byte finishes.
module tm1638_byte_engine #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_latch,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       sclk,
  input  logic       dio_in,
  output logic       dio_out,
`ifdef TM_BYTE_DONE_EN
  output logic       done,
`endif
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          mode, mode_nx;
  logic [7:0]    data_out_nx;
  logic          done_nx;
  logic          done_q;

  // Handshake: data_latch is a single-cycle request accepted unconditionally;
  // busy is high from the next clk until the byte completes or is aborted by a new latch.
  always_comb begin
    state_nx    = state;
    div_nx      = div_cnt;
    bit_nx      = bit_cnt;
    shift_nx    = shift;
    mode_nx     = mode;
    data_out_nx = data_out;
    done_nx     = 1'b0;
    if (data_latch) begin
      state_nx = LO;
      shift_nx = data_in;
      mode_nx  = rw;
      bit_nx   = 3'd0;
      div_nx   = '0;
    end else begin
      case (state)
        IDLE: ;
        LO: begin
          if (div_cnt == DIV_LAST) begin
            state_nx = HI;
            div_nx   = '0;
          end else begin
            div_nx = div_cnt + DW'(1);
          end
        end
        HI: begin
          // Read bits are taken on the sclk rising edge and enter from the top.
          if (!mode && div_cnt == '0) shift_nx = {dio_in, shift[7:1]};
          if (div_cnt == DIV_LAST) begin
            div_nx = '0;
            if (bit_cnt == 3'd7) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
              if (!mode) data_out_nx = shift;
            end else begin
              state_nx = LO;
              bit_nx   = bit_cnt + 3'd1;
              if (mode) shift_nx = {1'b0, shift[7:1]};
            end
          end else begin
            div_nx = div_cnt + DW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      mode     <= 1'b0;
      data_out <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      div_cnt  <= div_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      mode     <= mode_nx;
      data_out <= data_out_nx;
      done_q   <= done_nx;
    end
  end

  assign busy      = (state != IDLE);
  assign sclk      = (state != LO);
  assign dio_out   = (state != IDLE && mode) ? shift[0] : 1'b1;
  assign state_dbg = state;

`ifdef TM_BYTE_DONE_EN
  assign done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
`endif

endmodule
